// File: rtl/core_pkg.sv
// Shared types and default sizes for the core's memory-bus arbitration logic.
package core_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUS  = 2'd1,
    MEM_BUS = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Counter width able to hold 0..timeout; never narrower than one bit.
  function automatic int to_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_wdog.sv
// Bus watchdog: counts cycles a transaction waits without bus_ack and flags
// the cycle in which the count reaches TIMEOUT. TIMEOUT=0 disables it.
module bus_wdog
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = to_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expiry is the cycle whose missing ack would make the count equal TIMEOUT.
  assign expired = (TIMEOUT != 0) && tick && (cnt == LAST);

endmodule

// File: rtl/bus_arb.sv
// Shared memory bus arbiter for the IF and MEM stages: fixed MEM priority,
// one transaction at a time, registered ack/err pulses and a watchdog abort.
//
// state   | meaning
// IDLE    | bus free, sampling requests (MEM wins over IF)
// IF_BUS  | fetch transaction on the bus, waiting for bus_ack or timeout
// MEM_BUS | load/store transaction on the bus, waiting for bus_ack or timeout
// DONE    | one-cycle completion slot; ack/err visible, no new grant
module bus_arb
  import core_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_err,
  output logic                stallreq_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                mem_err,
  output logic                stallreq_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);

  arb_state_t state;
  logic       drop;
  logic       in_bus;
  logic       drop_now;
  logic       wd_clr;
  logic       wd_tick;
  logic       wd_expired;

  assign in_bus   = (state == IF_BUS) || (state == MEM_BUS);
  assign wd_clr   = !in_bus;
  assign wd_tick  = in_bus && !bus_ack;
  // A flush in the completing cycle also discards the fetch result.
  assign drop_now = drop || flush;

  bus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      mem_rdata <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      if_err  <= 1'b0;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            state     <= MEM_BUS;
          end else if (if_req) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= '1;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            drop      <= flush;
            state     <= IF_BUS;
          end
        end
        IF_BUS: begin
          if (flush) begin
            drop <= 1'b1;
          end
          if (bus_ack) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            state   <= DONE;
            if (!drop_now) begin
              if_rdata <= bus_rdata;
              if_ack   <= 1'b1;
            end
          end else if (wd_expired) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            state   <= DONE;
            if (!drop_now) begin
              if_err <= 1'b1;
            end
          end
        end
        MEM_BUS: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            mem_rdata <= bus_rdata;
            mem_ack   <= 1'b1;
            state     <= DONE;
          end else if (wd_expired) begin
            bus_req <= 1'b0;
            mem_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stallreq_if  = if_req && !if_ack && !if_err;
  assign stallreq_mem = mem_req && !mem_ack && !mem_err;

endmodule

// File: tb/tb_bus_arb.sv
// Randomised scoreboard bench for bus_arb: requester and bus-slave models,
// expected bus transactions and completions queued at issue time.
module tb_bus_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack, if_err, stallreq_if;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [SW-1:0] mem_sel = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack, mem_err, stallreq_mem;
  logic          bus_req, bus_we;
  logic [SW-1:0] bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  always #5 clk = ~clk;

  bus_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .if_err(if_err), .stallreq_if(stallreq_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  // lat: cycle of bus_req-high in which the slave acks (1..TO); 0 = never
  typedef struct {
    logic          is_if;
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
  } bus_txn_t;

  typedef struct {
    logic          is_err;
    logic [DW-1:0] data;
  } cpl_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
  } mcmd_t;

  bus_txn_t      bus_q[$];
  cpl_t          if_exp[$];
  cpl_t          mem_exp[$];
  logic [AW-1:0] if_cmd[$];
  mcmd_t         mem_cmd[$];
  logic [DW-1:0] m_if_rd = '0;
  logic [DW-1:0] m_mem_rd = '0;
  bit            abort = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference model: a completion with latency within TO acks with the slave
  // data; no ack at all gives err and leaves the requester's rdata untouched.
  task automatic issue_if(input logic [AW-1:0] a, input int lat, input logic [DW-1:0] d);
    bus_txn_t t;
    cpl_t c;
    t.is_if = 1'b1; t.addr = a; t.we = 1'b0; t.sel = '1; t.wdata = '0;
    t.lat = lat; t.rdata = d;
    bus_q.push_back(t);
    if_cmd.push_back(a);
    if (lat == 0) begin c.is_err = 1'b1; c.data = m_if_rd; end
    else begin c.is_err = 1'b0; c.data = d; m_if_rd = d; end
    if_exp.push_back(c);
  endtask

  task automatic issue_mem(input logic [AW-1:0] a, input logic we, input logic [SW-1:0] sel,
                           input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] d);
    bus_txn_t t;
    cpl_t c;
    mcmd_t m;
    t.is_if = 1'b0; t.addr = a; t.we = we; t.sel = sel; t.wdata = wd;
    t.lat = lat; t.rdata = d;
    bus_q.push_back(t);
    m.addr = a; m.we = we; m.sel = sel; m.wdata = wd;
    mem_cmd.push_back(m);
    if (lat == 0) begin c.is_err = 1'b1; c.data = m_mem_rd; end
    else begin c.is_err = 1'b0; c.data = d; m_mem_rd = d; end
    mem_exp.push_back(c);
  endtask

  // IF requester: holds if_req until one cycle after ack/err.
  initial begin : if_drv
    int n;
    bit seen;
    forever begin
      @(posedge clk); #1;
      if (if_cmd.size() != 0 && !abort) begin
        if_addr = if_cmd.pop_front();
        if_req = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && !abort && n < 100) begin
          @(posedge clk); #1; n++;
          if (if_ack || if_err) seen = 1'b1;
        end
        if (seen) begin
          @(posedge clk); #1;
        end else if (!abort) begin
          fail_note("if_wait", "no if_ack/if_err within 100 cycles, want completion");
        end
        if_req = 1'b0;
      end
    end
  end

  initial begin : mem_drv
    mcmd_t c;
    int n;
    bit seen;
    forever begin
      @(posedge clk); #1;
      if (mem_cmd.size() != 0 && !abort) begin
        c = mem_cmd.pop_front();
        mem_addr = c.addr; mem_we = c.we; mem_sel = c.sel; mem_wdata = c.wdata;
        mem_req = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && !abort && n < 100) begin
          @(posedge clk); #1; n++;
          if (mem_ack || mem_err) seen = 1'b1;
        end
        if (seen) begin
          @(posedge clk); #1;
        end else if (!abort) begin
          fail_note("mem_wait", "no mem_ack/mem_err within 100 cycles, want completion");
        end
        mem_req = 1'b0;
      end
    end
  end

  // Bus slave: checks each transaction's fields against the expected order,
  // acks at the planned cycle and checks how long bus_req stayed high.
  initial begin : bus_rsp
    bus_txn_t cur;
    bit active;
    int cyc;
    active = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!active) begin
          active = 1'b1; cyc = 0;
          if (bus_q.size() == 0) begin
            fail_note("bus_unexpected", "bus_req with no expected transaction");
            cur.is_if = 1'b0; cur.addr = bus_addr; cur.we = bus_we; cur.sel = bus_sel;
            cur.wdata = bus_wdata; cur.lat = 1; cur.rdata = '0;
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", 64'(bus_addr), 64'(cur.addr));
            chk("bus_we", 64'(bus_we), 64'(cur.we));
            chk("bus_sel", 64'(bus_sel), 64'(cur.sel));
            if (!cur.is_if) chk("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
          end
        end else begin
          chk("bus_stable", {bus_addr, bus_sel, bus_we}, {cur.addr, cur.sel, cur.we});
        end
        cyc++;
        bus_ack = (cyc == cur.lat);
        bus_rdata = bus_ack ? cur.rdata : $urandom();
      end else begin
        if (active) begin
          if (rst && !abort) chk("bus_req_cycles", 64'(cyc), 64'((cur.lat == 0) ? TO : cur.lat));
          active = 1'b0;
        end
        // Stray acks while the bus is idle must be ignored.
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom();
      end
    end
  end

  cpl_t mon_e;
  always @(negedge clk) begin : mon
    if (rst) begin
      if (if_req) chk("stallreq_if", 64'(stallreq_if), 64'(!if_ack && !if_err));
      if (mem_req) chk("stallreq_mem", 64'(stallreq_mem), 64'(!mem_ack && !mem_err));
      if (if_ack || if_err) begin
        if (if_exp.size() == 0) begin
          fail_note("if_unexpected", "if_ack/if_err with nothing expected");
        end else begin
          mon_e = if_exp.pop_front();
          chk("if_kind", {if_ack, if_err}, {!mon_e.is_err, mon_e.is_err});
          chk("if_rdata", 64'(if_rdata), 64'(mon_e.data));
        end
      end
      if (mem_ack || mem_err) begin
        if (mem_exp.size() == 0) begin
          fail_note("mem_unexpected", "mem_ack/mem_err with nothing expected");
        end else begin
          mon_e = mem_exp.pop_front();
          chk("mem_kind", {mem_ack, mem_err}, {!mon_e.is_err, mon_e.is_err});
          chk("mem_rdata", 64'(mem_rdata), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus_q.size() != 0 || if_exp.size() != 0 || mem_exp.size() != 0 ||
            if_cmd.size() != 0 || mem_cmd.size() != 0 || if_req || mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_note(tag, "activity not drained within 300 cycles");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bus(input logic level, input string tag);
    int n;
    n = 0;
    while (bus_req !== level && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_note(tag, "bus_req did not reach expected level within 50 cycles");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus"}, {bus_req, bus_we, bus_sel, bus_addr}, 64'd0);
    chk({tag, "_wdata"}, 64'(bus_wdata), 64'd0);
    chk({tag, "_rdata"}, {if_rdata, mem_rdata}, 64'd0);
    chk({tag, "_pulses"}, {if_ack, if_err, mem_ack, mem_err}, 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [DW-1:0] prev;
    int kind;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    issue_if(32'h100, 2, 32'hDEADBEEF);
    wait_idle("fetch");
    chk("fetch_rdata_hold", 64'(if_rdata), 64'h0000_0000_DEAD_BEEF);

    issue_mem(32'h200, 1'b1, 4'h3, 32'h1234_5678, 1, 32'h0BAD_F00D);
    issue_if(32'h300, 3, 32'h3333_0001);
    wait_idle("contention");

    // Flush while the fetch is on the bus: refetch of the same address serves.
    prev = m_if_rd;
    begin
      bus_txn_t t;
      cpl_t c;
      t.is_if = 1'b1; t.addr = 32'h400; t.we = 1'b0; t.sel = '1; t.wdata = '0;
      t.lat = 3; t.rdata = 32'hAAAA_0001;
      bus_q.push_back(t);
      t.lat = 2; t.rdata = 32'hAAAA_0002;
      bus_q.push_back(t);
      c.is_err = 1'b0; c.data = 32'hAAAA_0002;
      if_exp.push_back(c);
      m_if_rd = 32'hAAAA_0002;
      if_cmd.push_back(32'h400);
    end
    wait_bus(1'b1, "flush_rise");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_bus(1'b0, "flush_fall");
    chk("flush_no_pulse", {if_ack, if_err}, 64'd0);
    chk("flush_rdata_kept", 64'(if_rdata), 64'(prev));
    wait_idle("flush_bus");

    // Flush in the grant cycle, then a timed-out refetch.
    prev = m_if_rd;
    begin
      bus_txn_t t;
      cpl_t c;
      t.is_if = 1'b1; t.addr = 32'h500; t.we = 1'b0; t.sel = '1; t.wdata = '0;
      t.lat = 2; t.rdata = 32'hBBBB_0001;
      bus_q.push_back(t);
      t.lat = 0;
      bus_q.push_back(t);
      c.is_err = 1'b1; c.data = prev;
      if_exp.push_back(c);
      if_cmd.push_back(32'h500);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_bus(1'b0, "grant_flush_fall");
    chk("grant_flush_no_pulse", {if_ack, if_err}, 64'd0);
    chk("grant_flush_rdata", 64'(if_rdata), 64'(prev));
    wait_idle("grant_flush");

    prev = m_mem_rd;
    issue_mem(32'h600, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    wait_idle("timeout");
    chk("timeout_rdata_kept", 64'(mem_rdata), 64'(prev));

    issue_mem(32'h700, 1'b0, 4'hF, 32'h0, TO, 32'hCAFE_F00D);
    wait_idle("race");
    chk("race_rdata", 64'(mem_rdata), 64'h0000_0000_CAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      if (kind != 0)
        issue_mem($urandom(), 1'($urandom_range(0, 1)), SW'($urandom()), $urandom(),
                  $urandom_range(0, TO), $urandom());
      if (kind != 1)
        issue_if($urandom(), $urandom_range(0, TO), $urandom());
      wait_idle("random");
    end

    // Asynchronous reset in the middle of a MEM transaction.
    begin
      bus_txn_t t;
      mcmd_t m;
      t.is_if = 1'b0; t.addr = 32'h800; t.we = 1'b1; t.sel = 4'h5; t.wdata = 32'h5555_AAAA;
      t.lat = 0; t.rdata = '0;
      bus_q.push_back(t);
      m.addr = 32'h800; m.we = 1'b1; m.sel = 4'h5; m.wdata = 32'h5555_AAAA;
      mem_cmd.push_back(m);
    end
    wait_bus(1'b1, "rst_rise");
    @(negedge clk);
    #2;
    abort = 1'b1;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    bus_q.delete();
    mem_exp.delete();
    if_exp.delete();
    m_if_rd = '0;
    m_mem_rd = '0;
    abort = 1'b0;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", {bus_req, if_ack, if_err, mem_ack, mem_err}, 64'd0);
    end
    issue_mem(32'h900, 1'b0, 4'hF, 32'h0, 1, 32'h9999_0000);
    wait_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
